imem_fetch_queue: RTL

IMEM_FETCH_QUEUE -- requirements
Module: imem_fetch_queue

---
 rtl/imem_fetch_queue_if.sv | 30 +++
 rtl/imem_fetch_queue.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/imem_fetch_queue_if.sv
// Fetch-queue bus: memory program port, redirect, and instruction output.
// slave = fetch queue side, master = core/loader side.
interface imem_fetch_queue_if #(
  parameter int AW = 8
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [63:0]   out_pc;
  logic          out_fault;

  modport master (
    output wr_en, wr_addr, wr_data,
    output redirect_valid, redirect_pc,
    output out_ready,
    input  out_valid, out_instr, out_pc, out_fault
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  redirect_valid, redirect_pc,
    input  out_ready,
    output out_valid, out_instr, out_pc, out_fault
  );
endinterface

// File: rtl/imem_fetch_queue.sv
// Byte-programmable instruction memory with a two-edge fetch pipeline
// feeding an FQ_DEPTH-entry queue. Ports: clk, reset, bus (slave).
module imem_fetch_queue #(
  parameter int          MEM_BYTES = 256,
  parameter int          FQ_DEPTH  = 4,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input  logic             clk,
  input  logic             reset,
  imem_fetch_queue_if.slave bus
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - 4);
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FQ_DEPTH);

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]    mem [MEM_BYTES];
  logic [63:0]   fetch_pc;

  logic          if_valid;
  logic          if_fault;
  logic [63:0]   if_pc;
  logic [31:0]   if_instr;

  logic [31:0]   q_instr [FQ_DEPTH];
  logic [63:0]   q_pc    [FQ_DEPTH];
  logic          q_fault [FQ_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          redirect;
  logic          live;
  logic          head_valid;
  logic [CW:0]   occ;
  logic          issue;
  logic          iss_fault;
  logic          push;
  logic          pop;
  logic [AW-1:0] a0, a1, a2, a3;

  assign redirect   = bus.redirect_valid;
  assign live       = !reset && !redirect;
  assign head_valid = (count != '0);

  // Entries already in the queue plus the one in the read stage.
  assign occ = {1'b0, count} + {{CW{1'b0}}, if_valid};

  assign iss_fault = (fetch_pc[1:0] != 2'b00) ||
                     (fetch_pc > LAST_PC);
  assign issue = live && (state_q == S_RUN) &&
                 (occ < DEPTH_V);
  assign push  = live && if_valid;
  assign pop   = live && head_valid && bus.out_ready;

  assign a0 = {fetch_pc[AW-1:2], 2'd0};
  assign a1 = {fetch_pc[AW-1:2], 2'd1};
  assign a2 = {fetch_pc[AW-1:2], 2'd2};
  assign a3 = {fetch_pc[AW-1:2], 2'd3};

  // Memory and registered read; the read sees the pre-write byte.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !reset)
      mem[bus.wr_addr] <= bus.wr_data;
    if (issue)
      if_instr <= iss_fault ? 32'h0 :
                  {mem[a0], mem[a1], mem[a2], mem[a3]};
  end

  always_comb begin
    state_d = state_q;
    if (redirect)
      state_d = S_RUN;
    else if (issue && iss_fault)
      state_d = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= S_RUN;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_fault <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= bus.redirect_pc;
      if_valid <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if_valid <= issue;
      if (issue) begin
        if_pc    <= fetch_pc;
        if_fault <= iss_fault;
        fetch_pc <= fetch_pc + 64'd4;
      end
      if (push)
        tail <= tail + PW'(1);
      if (pop)
        head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue is throttled by occ, so a push never lands on a live slot.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail] <= if_instr;
      q_pc[tail]    <= if_pc;
      q_fault[tail] <= if_fault;
    end
  end

  assign bus.out_valid = head_valid;
  assign bus.out_instr = head_valid ? q_instr[head] : 32'h0;
  assign bus.out_pc    = head_valid ? q_pc[head]    : 64'h0;
  assign bus.out_fault = head_valid ? q_fault[head] : 1'b0;

endmodule
